spike_rate_decoder: RTL and testbench

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_pkg.sv | 21 ++
 rtl/spike_edge_detect.sv | 21 ++
 rtl/spike_rate_decoder.sv | 138 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// rtl/spike_pkg.sv - shared constants, state type and window-length helper for the spike rate decoder
package spike_pkg;

  localparam int CNT_W_DEF     = 8;
  localparam int WIN_SEL_W     = 3;
  localparam int WIN_BASE_LOG2 = 4;
  localparam int WIN_IDX_W     = 11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  // Last cycle index of a window: (16 << sel) - 1
  function automatic logic [WIN_IDX_W-1:0] win_last(input logic [WIN_SEL_W-1:0] sel);
    logic [WIN_IDX_W-1:0] len;
    len = WIN_IDX_W'(1) << (WIN_BASE_LOG2 + int'(sel));
    return len - WIN_IDX_W'(1);
  endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// rtl/spike_edge_detect.sv - previous-spike register and rising-edge event pulse
module spike_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic spike_in,
  output logic spike_event
);

  logic spike_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike_in;
    end
  end

  assign spike_event = spike_in & ~spike_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike-rate counter with ready/valid result and inter-spike interval strobe
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 spike_in,
  input  logic [WIN_SEL_W-1:0] win_sel,
  output logic [CNT_W-1:0]     rate_out,
  output logic                 rate_valid,
  input  logic                 rate_ready,
  output logic [CNT_W-1:0]     isi_out,
  output logic                 isi_valid,
  output logic                 overrun,
  output logic                 sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state, state_nxt;
  logic                 count_en;
  logic                 spike_event;
  logic [WIN_IDX_W-1:0] win_idx, win_last_q, win_last_cur;
  logic                 win_end;
  logic [CNT_W-1:0]     win_cnt, win_total;
  logic                 cnt_full;
  logic [CNT_W-1:0]     isi_cnt;
  logic                 isi_armed;
  logic                 accept;

  spike_edge_detect u_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike_in    (spike_in),
    .spike_event (spike_event)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ena)  state_nxt = ST_COUNT;
      ST_COUNT: if (!ena) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    count_en = 1'b0;
    if (state == ST_COUNT && ena) count_en = 1'b1;
  end

  // Window length is taken live from win_sel at index 0 and frozen for the rest of the window
  assign win_last_cur = (win_idx == '0) ? win_last(win_sel) : win_last_q;
  assign win_end      = count_en && (win_idx == win_last_cur);
  assign cnt_full     = (win_cnt == CNT_MAX);
  assign win_total    = (spike_event && !cnt_full) ? win_cnt + CNT_W'(1) : win_cnt;
  assign accept       = rate_valid & rate_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || !count_en) begin
      win_idx    <= '0;
      win_cnt    <= '0;
      win_last_q <= '0;
    end else begin
      if (win_idx == '0) win_last_q <= win_last_cur;
      if (win_end) begin
        win_idx <= '0;
        win_cnt <= '0;
      end else begin
        win_idx <= win_idx + WIN_IDX_W'(1);
        win_cnt <= win_total;
      end
    end
  end

  // A held result wins over a new one unless it is being accepted this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate_out   <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (win_end) begin
      if (!rate_valid || accept) begin
        rate_out   <= win_total;
        rate_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (accept) begin
      rate_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isi_out   <= '0;
      isi_valid <= 1'b0;
      isi_cnt   <= '0;
      isi_armed <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (!count_en) begin
        isi_cnt   <= '0;
        isi_armed <= 1'b0;
      end else if (spike_event) begin
        if (isi_armed) begin
          isi_out   <= isi_cnt;
          isi_valid <= 1'b1;
        end
        isi_armed <= 1'b1;
        isi_cnt   <= CNT_W'(1);
      end else if (isi_armed && isi_cnt != CNT_MAX) begin
        isi_cnt <= isi_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat <= 1'b0;
    end else if (count_en && ((spike_event && cnt_full) ||
                              (!spike_event && isi_armed && isi_cnt == CNT_MAX))) begin
      sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - self-checking bench for spike_rate_decoder
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       spike_in = 1'b0;
  logic [2:0] win_sel = 3'd0;
  logic       rate_ready = 1'b0;
  logic [7:0] rate_out;
  logic       rate_valid;
  logic [7:0] isi_out;
  logic       isi_valid;
  logic       overrun;
  logic       sat;

  int checks = 0;
  int errors = 0;

  spike_rate_decoder #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spike_in   (spike_in),
    .win_sel    (win_sel),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .isi_out    (isi_out),
    .isi_valid  (isi_valid),
    .overrun    (overrun),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: windows tracked by start cycle and length, events counted as plain integers,
  // intervals taken as differences of event cycle numbers.
  int   m_cyc = 0;
  bit   m_started = 0;
  bit   m_prev = 0, m_active = 0, m_win_open = 0;
  int   m_win_start = 0, m_win_len = 16, m_nev = 0, m_last_ev = -1;
  int   e_rate = 0, e_isi = 0;
  bit   e_rv = 0, e_iv = 0, e_ovr = 0, e_sat = 0;

  always @(posedge clk) begin : model
    bit ev, accept, newres;
    int res, d;
    m_started = 1;
    if (!rst_n) begin
      m_prev = 0; m_active = 0; m_win_open = 0; m_last_ev = -1; m_nev = 0;
      e_rate = 0; e_isi = 0; e_rv = 0; e_iv = 0; e_ovr = 0; e_sat = 0;
    end else begin
      ev = spike_in && !m_prev;
      m_prev = spike_in;
      accept = e_rv && rate_ready;
      newres = 0;
      res = 0;
      e_iv = 0;
      if (!m_active) begin
        if (ena) begin
          m_active = 1; m_win_open = 0; m_last_ev = -1;
        end
      end else if (!ena) begin
        m_active = 0;
      end else begin
        if (!m_win_open || m_cyc == m_win_start + m_win_len) begin
          m_win_open = 1; m_win_start = m_cyc; m_win_len = 16 << win_sel; m_nev = 0;
        end
        if (ev) begin
          m_nev++;
          if (m_nev > 255) e_sat = 1;
          if (m_last_ev >= 0) begin
            d = m_cyc - m_last_ev;
            e_isi = (d > 255) ? 255 : d;
            e_iv = 1;
          end
          m_last_ev = m_cyc;
        end else if (m_last_ev >= 0 && m_cyc - m_last_ev >= 255) begin
          e_sat = 1;
        end
        if (m_cyc == m_win_start + m_win_len - 1) begin
          newres = 1;
          res = (m_nev > 255) ? 255 : m_nev;
        end
      end
      if (newres) begin
        if (!e_rv || accept) begin
          e_rate = res; e_rv = 1;
        end else begin
          e_ovr = 1;
        end
      end else if (accept) begin
        e_rv = 0;
      end
    end
    m_cyc++;
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("m_rate_out",   int'(rate_out),   e_rate);
      check("m_rate_valid", int'(rate_valid), int'(e_rv));
      check("m_isi_valid",  int'(isi_valid),  int'(e_iv));
      check("m_isi_out",    int'(isi_out),    e_isi);
      check("m_overrun",    int'(overrun),    int'(e_ovr));
      check("m_sat",        int'(sat),        int'(e_sat));
    end
  end

  int isi_q[$];
  int res_q[$];

  task automatic step();
    @(posedge clk);
    #1;
    if (isi_valid) isi_q.push_back(int'(isi_out));
  endtask

  task automatic go_idle();
    ena = 1'b0; spike_in = 1'b0; rate_ready = 1'b1;
    step(); step();
  endtask

  initial begin
    int n, t1, t2;
    repeat (3) step();
    check("rst_rate_out", int'(rate_out), 0);
    check("rst_rate_valid", int'(rate_valid), 0);
    check("rst_isi_valid", int'(isi_valid), 0);
    check("rst_sat", int'(sat), 0);
    rst_n = 1'b1;
    step();

    // Alternating spikes, 16-cycle window
    win_sel = 3'd0; rate_ready = 1'b0; ena = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      spike_in = ~spike_in;
      step(); n++;
      if (rate_valid) break;
    end
    check("pulse_latency", n, 17);
    check("pulse_rate", int'(rate_out), 8);
    go_idle();

    // Level held high 40 cycles counts once
    ena = 1'b1; res_q.delete();
    for (int k = 0; k < 200 && res_q.size() < 2; k++) begin
      spike_in = (k >= 3 && k < 43);
      step();
      if (rate_valid) res_q.push_back(int'(rate_out));
    end
    check("level_nres", res_q.size(), 2);
    if (res_q.size() == 2) begin
      check("level_res0", res_q[0], 1);
      check("level_res1", res_q[1], 0);
    end
    check("level_sat", int'(sat), 0);
    go_idle();

    // ISI 10, then a 300-cycle gap saturating to 255
    isi_q.delete(); win_sel = 3'd7; ena = 1'b1;
    step();
    for (int p = 0; p < 4; p++) begin
      spike_in = 1'b1; step();
      spike_in = 1'b0; repeat (9) step();
    end
    repeat (290) step();
    spike_in = 1'b1; step();
    spike_in = 1'b0; step(); step();
    check("isi_count", isi_q.size(), 4);
    if (isi_q.size() == 4) begin
      check("isi_0", isi_q[0], 10);
      check("isi_1", isi_q[1], 10);
      check("isi_2", isi_q[2], 10);
      check("isi_3", isi_q[3], 255);
    end
    check("isi_sat", int'(sat), 1);
    go_idle();

    // Backpressure: overrun, then same-cycle accept and reload
    win_sel = 3'd0; rate_ready = 1'b0; ena = 1'b1;
    step();
    for (int w = 1; w <= 3; w++) begin
      for (int k = 0; k < 16; k++) begin
        spike_in = (k % 2 == 1) && (k < 2 * w);
        if (w == 3 && k == 15) rate_ready = 1'b1;
        step();
      end
      if (w == 1) check("bp_first", int'(rate_out), 1);
      if (w == 2) begin
        check("bp_held", int'(rate_out), 1);
        check("bp_overrun", int'(overrun), 1);
      end
    end
    check("bp_third", int'(rate_out), 3);
    check("bp_valid", int'(rate_valid), 1);
    go_idle();

    // win_sel change mid-window only affects the next window
    win_sel = 3'd0; ena = 1'b1;
    step();
    n = 0; t1 = -1; t2 = -1;
    for (int i = 0; i < 200 && t2 < 0; i++) begin
      if (n == 5) win_sel = 3'd2;
      step(); n++;
      if (rate_valid) begin
        if (t1 < 0) t1 = n; else t2 = n;
      end
    end
    check("ws_first_len", t1, 16);
    check("ws_second_end", t2, 80);
    win_sel = 3'd0;
    go_idle();

    // Reset mid-window with a pending result
    rate_ready = 1'b0; ena = 1'b1;
    step();
    for (int i = 0; i < 21; i++) begin
      spike_in = ~spike_in; step();
    end
    check("pre_rst_valid", int'(rate_valid), 1);
    spike_in = 1'b0; rst_n = 1'b0;
    step();
    check("rst2_rate_out", int'(rate_out), 0);
    check("rst2_rate_valid", int'(rate_valid), 0);
    check("rst2_overrun", int'(overrun), 0);
    check("rst2_sat", int'(sat), 0);
    rst_n = 1'b1;
    step();
    spike_in = 1'b1; step();
    spike_in = 1'b0; repeat (15) step();
    check("post_rst_valid", int'(rate_valid), 1);
    check("post_rst_rate", int'(rate_out), 1);
    go_idle();

    // 512-cycle window with 256 events saturates the count
    win_sel = 3'd5; ena = 1'b1;
    n = 0;
    for (int i = 0; i < 700; i++) begin
      spike_in = ~spike_in;
      step(); n++;
      if (rate_valid) break;
    end
    check("big_latency", n, 513);
    check("big_rate", int'(rate_out), 255);
    check("big_sat", int'(sat), 1);
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
